hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_sat_counter.sv | 18 +
 rtl/hazard_control_unit.sv | 134 +++++++++++++
 tb/tb_hazard_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and default branch opcode.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  localparam logic [3:0] BRANCH_OP_DEF = 4'b1011;
endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     count_q <= '0;
    else if (inc && (count_q != '1))  count_q <= count_q + 1'b1;
  end

  assign count = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall / taken-branch flush controller with Moore outputs and saturating event counters.
// Define HAZARD_NO_FORWARD_EN for a full RAW interlock (no forwarding network in the pipeline).
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int              REG_ADDR_W   = 4,
  parameter int              OP_W         = 4,
  parameter logic [OP_W-1:0] BRANCH_OP    = OP_W'(BRANCH_OP_DEF),
  parameter int              STALL_CYCLES = 1,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [OP_W-1:0]       ex_op,
  input  logic                  ex_zero,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  idex_bubble,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // r0 is hardwired zero, so it can never carry a pending result
  logic rs1_ex, rs2_ex, lu, bt, hazard;
  assign rs1_ex = id_use_rs1 && (id_rs1 != '0) && (id_rs1 == ex_rd);
  assign rs2_ex = id_use_rs2 && (id_rs2 != '0) && (id_rs2 == ex_rd);
  assign lu     = ex_memread && ex_regwrite && (rs1_ex || rs2_ex);
  assign bt     = (ex_op == BRANCH_OP) && !ex_zero;

`ifdef HAZARD_NO_FORWARD_EN
  logic rs1_mem, rs2_mem;
  assign rs1_mem = id_use_rs1 && (id_rs1 != '0) && (id_rs1 == mem_rd);
  assign rs2_mem = id_use_rs2 && (id_rs2 != '0) && (id_rs2 == mem_rd);
  assign hazard  = lu || (ex_regwrite && (rs1_ex || rs2_ex))
                      || (mem_regwrite && (rs1_mem || rs2_mem));
`else
  logic unused_mem;
  assign unused_mem = ^{mem_rd, mem_regwrite};
  assign hazard     = lu;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bt) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (hazard) begin
          state_d = STALL;
          cnt_d   = STALL_INIT;
        end
      end
      STALL: begin
        if (bt) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - 3'd1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 3'd1;
        else             state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;
    flush         = 1'b0;
    case (state_q)
      STALL: begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_bubble   = 1'b1;
      end
      FLUSH: begin
        idex_bubble   = 1'b1;
        flush         = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (state_q == STALL),
    .count  (stall_count)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc    (state_q == FLUSH),
    .count  (flush_count)
  );
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed, table-driven bench for hazard_control_unit; a second narrow-counter instance covers saturation.
module tb_hazard_control_unit;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] id_rs1, id_rs2, ex_rd, mem_rd, ex_op;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, mem_regwrite, ex_zero;
  logic       pc_write_en, ifid_write_en, idex_bubble, flush;
  logic [15:0] stall_count, flush_count;
  logic       s_pc, s_ifid, s_bub, s_fl;
  logic [1:0] s_stall_count, s_flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hazard_control_unit dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .ex_op(ex_op), .ex_zero(ex_zero),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .idex_bubble(idex_bubble),
    .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_control_unit #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .ex_op(ex_op), .ex_zero(ex_zero),
    .pc_write_en(s_pc), .ifid_write_en(s_ifid), .idex_bubble(s_bub),
    .flush(s_fl), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0010;
  localparam logic [3:0] O_FLUSH = 4'b1111;

`ifdef HAZARD_NO_FORWARD_EN
  localparam logic [3:0] O_NF = O_STALL;
  localparam int         D_NF = 1;
`else
  localparam logic [3:0] O_NF = O_RUN;
  localparam int         D_NF = 0;
`endif

  typedef struct {
    string      name;
    logic [3:0] rs1, rs2;
    logic       u1, u2;
    logic [3:0] ex_rd;
    logic       memrd, exwr;
    logic [3:0] mem_rd;
    logic       memwr;
    logic [3:0] op;
    logic       zero;
    logic [3:0] exp_out;
    int         d_stall, d_flush;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [3:0] outs();
    return {pc_write_en, ifid_write_en, idex_bubble, flush};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_memread = 0; ex_regwrite = 0;
    mem_rd = 0; mem_regwrite = 0; ex_op = 0; ex_zero = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.ex_rd; ex_memread = v.memrd; ex_regwrite = v.exwr;
    mem_rd = v.mem_rd; mem_regwrite = v.memwr; ex_op = v.op; ex_zero = v.zero;
  endtask

  task automatic drive_bt();
    idle();
    ex_op = 4'b1011; ex_zero = 0;
  endtask

  task automatic drive_lu();
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
  endtask

  initial begin
    int s0, f0;
    //         name          rs1 rs2 u1 u2 exrd mr ew memrd mw op       z  out      ds    df
    vecs[0]  = '{"lu_rs1",     3, 0, 1, 0, 3,  1, 1, 0, 0, 4'b0000, 0, O_STALL, 1,    0};
    vecs[1]  = '{"lu_r0",      0, 0, 1, 0, 0,  1, 1, 0, 0, 4'b0000, 0, O_RUN,   0,    0};
    vecs[2]  = '{"bt_taken",   0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1011, 0, O_FLUSH, 0,    2};
    vecs[3]  = '{"bt_not",     0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1011, 1, O_RUN,   0,    0};
    vecs[4]  = '{"lu_and_bt",  3, 0, 1, 0, 3,  1, 1, 0, 0, 4'b1011, 0, O_FLUSH, 0,    2};
    vecs[5]  = '{"lu_unused",  3, 0, 0, 0, 3,  1, 1, 0, 0, 4'b0000, 0, O_RUN,   0,    0};
    vecs[6]  = '{"lu_rs2",     1, 7, 1, 1, 7,  1, 1, 0, 0, 4'b0000, 0, O_STALL, 1,    0};
    vecs[7]  = '{"load_nowr",  3, 0, 1, 0, 3,  1, 0, 0, 0, 4'b0000, 0, O_RUN,   0,    0};
    vecs[8]  = '{"mem_raw",    0, 5, 0, 1, 0,  0, 0, 5, 1, 4'b0000, 0, O_NF,    D_NF, 0};
    vecs[9]  = '{"ex_raw",     6, 0, 1, 0, 6,  0, 1, 0, 0, 4'b0000, 0, O_NF,    D_NF, 0};
    vecs[10] = '{"other_op",   0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0011, 0, O_RUN,   0,    0};

    idle();
    reset_n = 0;
    #2;
    chk("reset_outs", int'(outs()), int'(O_RUN));
    chk("reset_stall_count", int'(stall_count), 0);
    chk("reset_flush_count", int'(flush_count), 0);
    #10 reset_n = 1;
    step();
    chk("post_reset_outs", int'(outs()), int'(O_RUN));

    for (int i = 0; i < 11; i++) begin
      s0 = int'(stall_count);
      f0 = int'(flush_count);
      drive(vecs[i]);
      step();
      idle();
      chk({vecs[i].name, "_outs"}, int'(outs()), int'(vecs[i].exp_out));
      repeat (6) step();
      chk({vecs[i].name, "_settle"}, int'(outs()), int'(O_RUN));
      chk({vecs[i].name, "_dstall"}, int'(stall_count) - s0, vecs[i].d_stall);
      chk({vecs[i].name, "_dflush"}, int'(flush_count) - f0, vecs[i].d_flush);
    end

    // flush lasts exactly two cycles
    f0 = int'(flush_count);
    drive_bt(); step(); idle();
    chk("fl_seq_c1", int'(flush), 1);
    step();
    chk("fl_seq_c2", int'(flush), 1);
    step();
    chk("fl_seq_c3", int'(outs()), int'(O_RUN));
    chk("fl_seq_count", int'(flush_count) - f0, 2);

    // branch arriving while stalled preempts the stall
    s0 = int'(stall_count);
    f0 = int'(flush_count);
    drive_lu(); step();
    chk("pre_stall", int'(outs()), int'(O_STALL));
    drive_bt(); step(); idle();
    chk("pre_flush1", int'(outs()), int'(O_FLUSH));
    step();
    chk("pre_flush2", int'(outs()), int'(O_FLUSH));
    step();
    chk("pre_run", int'(outs()), int'(O_RUN));
    chk("pre_dstall", int'(stall_count) - s0, 1);
    chk("pre_dflush", int'(flush_count) - f0, 2);

    // asynchronous reset in the middle of a flush
    drive_bt(); step(); idle();
    chk("mid_fl_active", int'(flush), 1);
    reset_n = 0;
    #1;
    chk("mid_fl_rst_flush", int'(flush), 0);
    chk("mid_fl_rst_outs", int'(outs()), int'(O_RUN));
    chk("mid_fl_rst_scnt", int'(stall_count), 0);
    chk("mid_fl_rst_fcnt", int'(flush_count), 0);
    #2 reset_n = 1;
    step();
    chk("mid_fl_after", int'(outs()), int'(O_RUN));
    chk("mid_fl_after_fcnt", int'(flush_count), 0);

    // three taken branches: 6 flush cycles, 2-bit counter pins at 3
    for (int k = 0; k < 3; k++) begin
      drive_bt(); step(); idle();
      repeat (3) step();
    end
    chk("sat_wide_fcnt", int'(flush_count), 6);
    chk("sat_narrow_fcnt", int'(s_flush_count), 3);
    chk("sat_narrow_outs", int'({s_pc, s_ifid, s_bub, s_fl}), int'(O_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
